// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-requester ALU arbiter:
// control codes, the supported-code check and the response-stage state encoding.
package alu_pkg;

  localparam int ALU_W  = 32;
  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_NOR = 4'b1100;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_t;

  // High for the six control codes the ALU implements.
  function automatic logic alu_ctrl_valid(input logic [CTRL_W-1:0] ctrl);
    logic ok;
    case (ctrl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: ok = 1'b1;
      default:                                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Unsupported control codes produce out=0
// (hence zero=1) and overflow=0; overflow is meaningful for ADD/SUB only.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_W
) (
  input  logic        [CTRL_W-1:0] i_ctrl,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_out,
  output logic                     o_zero,
  output logic                     o_overflow
);

  logic signed [DATA_W-1:0] w_sum;
  logic signed [DATA_W-1:0] w_diff;
  logic                     w_lt;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign w_lt   = (i_a < i_b);

  // Operation select and signed overflow detection.
  always_comb begin
    o_out      = '0;
    o_overflow = 1'b0;
    case (i_ctrl)
      ALU_AND: o_out = i_a & i_b;
      ALU_OR:  o_out = i_a | i_b;
      ALU_NOR: o_out = ~(i_a | i_b);
      ALU_ADD: begin
        o_out      = w_sum;
        o_overflow = (i_a[DATA_W-1] == i_b[DATA_W-1]) &&
                     (w_sum[DATA_W-1] != i_a[DATA_W-1]);
      end
      ALU_SUB: begin
        o_out      = w_diff;
        o_overflow = (i_a[DATA_W-1] != i_b[DATA_W-1]) &&
                     (w_diff[DATA_W-1] != i_a[DATA_W-1]);
      end
      ALU_SLT: o_out = {{(DATA_W-1){1'b0}}, w_lt};
      default: o_out = '0;
    endcase
  end

  assign o_zero = (o_out == '0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. gnt names the candidate among the active
// requests; the priority pointer moves to the other requester only when
// the caller signals that the grant was actually taken (advance).
module rr_arb2 #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic r_ptr;

  // Candidate selection: a lone request wins, a tie goes to the pointer.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer moves past the requester just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= RR_INIT;
    end else if (advance) begin
      r_ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters. One request is granted
// per cycle (round-robin on ties) and its result lands in a single-entry
// response register tagged with the requester ID. The response drains and
// refills on the same edge, so back-to-back throughput is one op per cycle.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ALU_W-1:0]  req0_a,
  input  logic [ALU_W-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ALU_W-1:0]  req1_a,
  input  logic [ALU_W-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [ALU_W-1:0]  rsp_out,
  output logic              rsp_zero,
  output logic              rsp_overflow,
  output logic              rsp_err
);

  rsp_state_t               r_state;
  logic                     r_id_p1;
  logic signed [ALU_W-1:0]  w_out_p0;
  logic signed [ALU_W-1:0]  r_out_p1;
  logic                     r_zero_p1;
  logic                     r_ovf_p1;
  logic                     r_err_p1;

  logic                     w_can_accept;
  logic [1:0]               w_gnt;
  logic                     w_accept;
  logic                     w_sel;
  logic signed [ALU_W-1:0]  w_a_p0;
  logic signed [ALU_W-1:0]  w_b_p0;
  logic [CTRL_W-1:0]        w_ctrl_p0;
  logic                     w_zero_p0;
  logic                     w_ovf_p0;

  rr_arb2 #(
    .RR_INIT (RR_INIT)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid}),
    .advance (w_accept),
    .gnt     (w_gnt)
  );

  // A held response blocks new grants unless it is drained this cycle.
  assign w_can_accept = (r_state == RSP_EMPTY) || rsp_ready;
  assign req0_ready   = w_gnt[0] & w_can_accept;
  assign req1_ready   = w_gnt[1] & w_can_accept;
  assign w_accept     = req0_ready | req1_ready;
  assign w_sel        = w_gnt[1];

  // ---- stage p0: granted operands into the shared ALU ----
  assign w_a_p0    = w_sel ? req1_a    : req0_a;
  assign w_b_p0    = w_sel ? req1_b    : req0_b;
  assign w_ctrl_p0 = w_sel ? req1_ctrl : req0_ctrl;

  alu #(
    .DATA_W (ALU_W)
  ) u_alu (
    .i_ctrl     (w_ctrl_p0),
    .i_a        (w_a_p0),
    .i_b        (w_b_p0),
    .o_out      (w_out_p0),
    .o_zero     (w_zero_p0),
    .o_overflow (w_ovf_p0)
  );

  // ---- stage p1: response register ----
  // Response FSM: refill on accept (even while draining), empty on a bare drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RSP_EMPTY;
      r_id_p1   <= 1'b0;
      r_out_p1  <= '0;
      r_zero_p1 <= 1'b0;
      r_ovf_p1  <= 1'b0;
      r_err_p1  <= 1'b0;
    end else if (w_accept) begin
      r_state   <= RSP_FULL;
      r_id_p1   <= w_sel;
      r_out_p1  <= w_out_p0;
      r_zero_p1 <= w_zero_p0;
      r_ovf_p1  <= w_ovf_p0;
      r_err_p1  <= ~alu_ctrl_valid(w_ctrl_p0);
    end else if ((r_state == RSP_FULL) && rsp_ready) begin
      r_state   <= RSP_EMPTY;
    end
  end

  assign rsp_valid    = (r_state == RSP_FULL);
  assign rsp_id       = r_id_p1;
  assign rsp_out      = r_out_p1;
  assign rsp_zero     = r_zero_p1;
  assign rsp_overflow = r_ovf_p1;
  assign rsp_err      = r_err_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: hand-computed expectations checked with
// immediate assertions after each step.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_overflow, rsp_err;
  logic [31:0] rsp_out;

  int n_vec = 0;
  int n_err = 0;

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_ctrl    (req0_ctrl),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_ctrl    (req1_ctrl),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_out      (rsp_out),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic id,
                         input logic [31:0] o, input logic z, input logic ov, input logic e);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'(v));
    chk({tag, "_id"},    32'(rsp_id), 32'(id));
    chk({tag, "_out"},   rsp_out, o);
    chk({tag, "_zero"},  32'(rsp_zero), 32'(z));
    chk({tag, "_ovf"},   32'(rsp_overflow), 32'(ov));
    chk({tag, "_err"},   32'(rsp_err), 32'(e));
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    #1;
    chk({tag, "_rdy0"}, 32'(req0_ready), 32'(r0));
    chk({tag, "_rdy1"}, 32'(req1_ready), 32'(r1));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b;
  endtask

  task automatic drv1(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b;
  endtask

  initial begin
    logic got;
    rst = 1'b1;
    rsp_ready = 1'b1;
    drv0(1'b0, 4'h0, 32'h0, 32'h0);
    drv1(1'b0, 4'h0, 32'h0, 32'h0);
    tick;
    rst = 1'b0;
    chk_rsp("reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk_rdy("idle", 1'b0, 1'b0);

    // Single ADD with signed overflow
    drv0(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    chk_rdy("single", 1'b1, 1'b0);
    tick;
    drv0(1'b0, 4'h0, 32'h0, 32'h0);
    chk_rsp("single", 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    tick;
    chk("drain_valid", 32'(rsp_valid), 32'd0);
    chk("drain_hold_out", rsp_out, 32'h8000_0000);

    // Re-reset so the tie starts at requester 0
    rst = 1'b1;
    tick;
    rst = 1'b0;

    // Simultaneous requests alternate 0,1,0,1
    drv0(1'b1, 4'b0110, 32'd5, 32'd5);
    drv1(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1);
    for (int i = 0; i < 2; i++) begin
      chk_rdy("alt_a", 1'b1, 1'b0);
      tick;
      chk_rsp("alt_a", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk_rdy("alt_b", 1'b0, 1'b1);
      tick;
      chk_rsp("alt_b", 1'b1, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
    end
    drv0(1'b0, 4'h0, 32'h0, 32'h0);
    drv1(1'b0, 4'h0, 32'h0, 32'h0);
    tick;

    // Backpressure: hold OR result, req1 waits, then refill on drain
    drv0(1'b1, 4'b0001, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    tick;
    drv0(1'b0, 4'h0, 32'h0, 32'h0);
    drv1(1'b1, 4'b0010, 32'd2, 32'd3);
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_rdy("bp", 1'b0, 1'b0);
      tick;
      chk("bp_out", rsp_out, 32'hFFFF_FFFF);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
    end
    rsp_ready = 1'b1;
    chk_rdy("refill", 1'b0, 1'b1);
    tick;
    chk_rsp("refill", 1'b1, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0);

    // Unsupported control code
    drv1(1'b1, 4'b1111, 32'd3, 32'd4);
    chk_rdy("inv", 1'b0, 1'b1);
    tick;
    drv1(1'b0, 4'h0, 32'h0, 32'h0);
    chk_rsp("inv", 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);

    // Push ptr to requester 1, then reset mid-operation with both requests up
    drv0(1'b1, 4'b0000, 32'hFFFF_0000, 32'h0F0F_0F0F);
    tick;
    chk_rsp("and", 1'b1, 1'b0, 32'h0F0F_0000, 1'b0, 1'b0, 1'b0);
    rsp_ready = 1'b0;
    drv0(1'b1, 4'b0010, 32'd1, 32'd1);
    drv1(1'b1, 4'b0001, 32'd1, 32'd2);
    rst = 1'b1;
    chk_rdy("rst_mid", 1'b0, 1'b0);
    tick;
    rst = 1'b0;
    chk_rsp("rst_mid", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    rsp_ready = 1'b1;
    chk_rdy("post_rst", 1'b1, 1'b0);
    tick;
    chk_rsp("post_rst", 1'b1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);

    // Starvation: req0 stays valid, req1 asserts once
    drv1(1'b0, 4'h0, 32'h0, 32'h0);
    tick;
    chk("solo_id", 32'(rsp_id), 32'd0);
    drv1(1'b1, 4'b0001, 32'd1, 32'd2);
    got = 1'b0;
    for (int k = 0; k < 2 && !got; k++) begin
      #1;
      if (req1_ready) got = 1'b1;
      tick;
    end
    drv1(1'b0, 4'h0, 32'h0, 32'h0);
    chk("starve_gnt", 32'(got), 32'd1);
    chk_rsp("starve", 1'b1, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
    chk_rdy("after_starve", 1'b1, 1'b0);
    tick;
    chk_rsp("after_starve", 1'b1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
    drv0(1'b0, 4'h0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
